fre_bcd_conv: RTL
=================

Name: fre_bcd_conv

Overview:
Downstream consumer of the frequency counter's 32-bit result (Hz). It converts the binary frequency word to packed BCD digits with a sequential shift-and-add-3 (double-dabble) engine, one bit per clock. It also produces leading-zero blanking information for the 7-segment/LCD display driver that follows it. The upstream frequency value is treated as quasi-static; a start pulse snapshots it.

Parameters:
IN_W, 32, width of binary input; must be ≥1.
DIGITS, 10, number of BCD digits produced; must satisfy 10^DIGITS > 2^IN_W - 1 (10 for 32).
CNT_W, 4, width of nz_digits; must hold the value DIGITS.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to convert bin_in; sampled only when idle.
bin_in  in  IN_W  binary frequency value (Hz, unsigned).
busy  out  1  high while a conversion is in progress.
valid  out  1  one-cycle pulse when bcd/blank/nz_digits have just been updated.
bcd  out  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
blank  out  DIGITS  bit i = 1 if digit i is a leading zero; bit 0 is always 0.
nz_digits  out  CNT_W  count of significant digits, 1..DIGITS (0 converts to 1).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset, when rst=1 at a clk edge:
  - state=IDLE; busy=0; valid=0.
  - bcd=0; blank=all ones except bit 0; nz_digits=1.
  - Internal shift register, work digits and bit counter are cleared.
  - Reset overrides start and aborts any conversion in progress. The aborted conversion produces no valid pulse, and bcd keeps its reset value.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 at edge t loads shift register ← bin_in and work digits ← 0, clears the bit counter, and enters SHIFT.
  - busy=1 from cycle t+1.
  - start=0 stays in IDLE.
- SHIFT, one step per cycle for exactly IN_W cycles (t+1 .. t+IN_W):
  - Every work digit ≥5 gets +3 (4-bit, no carry between digits).
  - The whole {work digits, shift register} vector then shifts left by 1; the MSB of the shift register enters digit 0 bit 0.
  - The bit counter increments.
- Completion, at the edge ending cycle t+IN_W:
  - bcd ← final digits (the post-shift value of the last step).
  - blank and nz_digits are computed from those same final digits and registered at the same edge.
  - valid ← 1 for exactly one cycle; busy ← 0; state ← IDLE.
  - Latency from start edge to the valid-high cycle: IN_W+1 cycles (33 by default).
- start while busy=1: ignored, with no queueing. bin_in changes during SHIFT have no effect.
- start=1 in the valid-high cycle: accepted, since the state is already IDLE. This gives back-to-back conversions every IN_W+1 cycles.
- Outputs hold their last result between conversions. bcd, blank and nz_digits never show intermediate values.
- Leading-zero rules:
  - blank[i]=1 if and only if digit i and all digits above it are 0, for i ≥1.
  - nz_digits = DIGITS minus the number of ones in blank.
- Widths:
  - Work digit add-3 is 4-bit.
  - The DIGITS constraint guarantees no digit exceeds 9 and no overflow out of the top digit. This is not checked at runtime.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → bcd=0, blank=10'b1111111110, nz_digits=1, busy=0, valid=0.
- bin_in=0, start pulse → valid exactly 33 cycles after the start edge; bcd=0, nz_digits=1; busy high for 32 cycles.
- bin_in=19_999_800 (99_999×200) → bcd=40'h0019999800, blank=10'b1100000000, nz_digits=8.
- bin_in=32'hFFFF_FFFF → bcd=40'h4294967295, blank=0, nz_digits=10. Then bin_in=7 with start in the valid cycle → next valid 33 cycles later, bcd=40'h0000000007, nz_digits=1.
- Start bin_in=1234, then pulse start again with bin_in=9 at cycle 10 of SHIFT → single valid pulse only, bcd=40'h0000001234.
- Start bin_in=500, assert rst at cycle 15 of SHIFT → no valid pulse, outputs return to reset values, busy=0. A subsequent start with bin_in=500 yields bcd=40'h0000000500 after 33 cycles.

Source files
------------

// File: rtl/fre_bcd_conv_if.sv
// Handshake/result bundle between a converter client and fre_bcd_conv.
//   start     : one-cycle convert request (client -> converter)
//   bin_in    : binary value to convert (client -> converter)
//   busy      : conversion in progress (converter -> client)
//   valid     : one-cycle pulse, results just updated (converter -> client)
//   bcd       : packed BCD digits, units in [3:0]
//   blank     : leading-zero flags per digit, bit 0 always 0
//   nz_digits : count of significant digits, 1..DIGITS
interface fre_bcd_conv_if #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10,
    parameter int CNT_W  = 4
);
    logic                  start;
    logic [IN_W-1:0]       bin_in;
    logic                  busy;
    logic                  valid;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic [CNT_W-1:0]      nz_digits;

    modport master (
        output start, bin_in,
        input  busy, valid, bcd, blank, nz_digits
    );

    modport slave (
        input  start, bin_in,
        output busy, valid, bcd, blank, nz_digits
    );
endinterface

// File: rtl/fre_bcd_conv.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// leading-zero blanking for the display driver downstream.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any conversion
//   bus : fre_bcd_conv_if.slave (start/bin_in in; busy/valid/bcd/blank/nz_digits out)
// A start in IDLE snapshots bin_in; IN_W shift cycles later the result,
// blank mask and digit count are registered together with a valid pulse.
module fre_bcd_conv #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10,
    parameter int CNT_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    fre_bcd_conv_if.slave  bus
);
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [DIGITS-1:0] RST_BLANK = ~DIGITS'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nxt;
    logic [IN_W-1:0]     sr, sr_nxt;
    logic [4*DIGITS-1:0] work, adj, work_nxt;
    logic [CW-1:0]       cnt;
    logic                last;
    logic [DIGITS-1:0]   blank_c;
    logic [CNT_W-1:0]    nz_c;

    logic                valid_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   blank_q;
    logic [CNT_W-1:0]    nz_q;
    logic                busy_c;

    assign last = (cnt == CW'(IN_W - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = SHIFT;
            SHIFT: if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_c = (state == SHIFT);
    end

    // One double-dabble step: add-3 on digits >= 5 (no inter-digit carry),
    // then shift the concatenated {digits, shift register} left by one.
    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            adj[d*4 +: 4] = (work[d*4 +: 4] >= 4'd5) ? work[d*4 +: 4] + 4'd3
                                                     : work[d*4 +: 4];
        end
        {work_nxt, sr_nxt} = {adj, sr} << 1;
    end

    // Blanking from the final digits: scan from the top, a digit is blank
    // until the first nonzero digit is seen. Units digit is never blanked.
    always_comb begin
        logic             seen;
        logic [CNT_W-1:0] zeros;
        seen    = 1'b0;
        zeros   = '0;
        blank_c = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (work_nxt[i*4 +: 4] != 4'd0) seen = 1'b1;
            blank_c[i] = ~seen;
            zeros      = zeros + CNT_W'(blank_c[i]);
        end
        nz_c = CNT_W'(DIGITS) - zeros;
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            work    <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            blank_q <= RST_BLANK;
            nz_q    <= CNT_W'(1);
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr   <= bus.bin_in;
                        work <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    sr   <= sr_nxt;
                    work <= work_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        bcd_q   <= work_nxt;
                        blank_q <= blank_c;
                        nz_q    <= nz_c;
                        valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_c;
    assign bus.valid     = valid_q;
    assign bus.bcd       = bcd_q;
    assign bus.blank     = blank_q;
    assign bus.nz_digits = nz_q;
endmodule
